threshold_pixel: RTL and testbench

- Downstream stage of the max-pixel fold actor in the threshold benchmark.
- Accepts one 8-bit max token on the Max port. Derives a threshold from it, then streams exactly PIXEL_COUNT image pixels from In1 to Out1.
- Each output pixel is binarised: FG if pixel > threshold, otherwise BG.
- After the last pixel it returns to waiting for the next max token, so it handles one frame per max token.

---
 rtl/thresh_pkg.sv | 26 ++
 rtl/threshold_pixel_if.sv | 40 ++++
 rtl/thresh_out_reg.sv | 77 +++++++
 rtl/threshold_pixel.sv | 133 +++++++++++++
 tb/tb_threshold_pixel.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/thresh_pkg.sv
// ---------------------------------------------------------------------------
// thresh_pkg
// Shared types and constants for the threshold_pixel binarisation stage.
//   state_e      : controller state (WAIT_MAX, STREAM)
//   DATA_W_DEF   : default pixel / max token width
//   CNT_W        : width of the per-frame pixel counter
//   TOKCOUNT_W   : width of the *_COUNT token-count fields
//   FG_VAL_DEF / BG_VAL_DEF : default binarised output levels
// ---------------------------------------------------------------------------
package thresh_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W      = 32;
    localparam int unsigned TOKCOUNT_W = 16;

    localparam int unsigned FG_VAL_DEF = 255;
    localparam int unsigned BG_VAL_DEF = 0;

    // WAIT_MAX: waiting for the frame's max token.
    // STREAM  : passing the frame's pixels through the comparator.
    typedef enum logic [0:0] {
        WAIT_MAX = 1'b0,
        STREAM   = 1'b1
    } state_e;

endpackage : thresh_pkg

// File: rtl/threshold_pixel_if.sv
// ---------------------------------------------------------------------------
// threshold_pixel_if
// One token channel: data word, valid strobe, token count and the two
// consumer-to-producer responses (ACK, RDY).
//   master : producer side  -> drives DATA, SEND, COUNT; sees ACK, RDY
//   slave  : consumer side  -> sees DATA, SEND, COUNT; drives ACK, RDY
// For the Max and In1 channels the block is the slave and ACK is the
// consume strobe; RDY is an informational "would accept" level.
// For the Out1 channel the block is the master; RDY is flow control and
// ACK carries no meaning for this block.
// ---------------------------------------------------------------------------
interface threshold_pixel_if
    import thresh_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic [DATA_W-1:0]     DATA;
    logic                  SEND;
    logic [TOKCOUNT_W-1:0] COUNT;
    logic                  ACK;
    logic                  RDY;

    modport master (
        output DATA,
        output SEND,
        output COUNT,
        input  ACK,
        input  RDY
    );

    modport slave (
        input  DATA,
        input  SEND,
        input  COUNT,
        output ACK,
        output RDY
    );

endinterface : threshold_pixel_if

// File: rtl/thresh_out_reg.sv
// ---------------------------------------------------------------------------
// thresh_out_reg
// Registered compare/select output stage. On a fire the incoming pixel is
// compared (unsigned, at full threshold width) against the threshold and
// the binarised value is registered together with a one-cycle send pulse.
// Without a fire the send pulse drops and the data word holds.
//
// Build option: define THRESH_INVERT_EN to swap the FG/BG selection
// (pixel above threshold then produces BG_VAL). Timing is identical.
//
// Ports:
//   clk_i   in   clock
//   rst_i   in   asynchronous, active-high reset (clears data and send)
//   fire_i  in   pixel accepted this cycle
//   pix_i   in   pixel being accepted
//   thr_i   in   current threshold, DATA_W+8 bits wide
//   data_o  out  registered binarised pixel
//   send_o  out  registered one-cycle valid pulse
// ---------------------------------------------------------------------------
module thresh_out_reg
    import thresh_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned THR_W  = DATA_W_DEF + 8,
    parameter int unsigned FG_VAL = FG_VAL_DEF,
    parameter int unsigned BG_VAL = BG_VAL_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fire_i,
    input  logic [DATA_W-1:0] pix_i,
    input  logic [THR_W-1:0]  thr_i,
    output logic [DATA_W-1:0] data_o,
    output logic              send_o
);

    localparam logic [DATA_W-1:0] FG = DATA_W'(FG_VAL);
    localparam logic [DATA_W-1:0] BG = DATA_W'(BG_VAL);

`ifdef THRESH_INVERT_EN
    localparam logic [DATA_W-1:0] ABOVE_VAL = BG;
    localparam logic [DATA_W-1:0] BELOW_VAL = FG;
`else
    localparam logic [DATA_W-1:0] ABOVE_VAL = FG;
    localparam logic [DATA_W-1:0] BELOW_VAL = BG;
`endif

    logic [DATA_W-1:0] data_q, data_d;
    logic              send_q, send_d;
    logic              above;

    // Pixel is zero-extended to the threshold width so a threshold above
    // the pixel range (large RATIO_NUM) simply never compares true.
    assign above = THR_W'(pix_i) > thr_i;

    always_comb begin
        send_d = fire_i;
        data_d = data_q;
        if (fire_i) begin
            data_d = above ? ABOVE_VAL : BELOW_VAL;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            send_q <= 1'b0;
        end else begin
            data_q <= data_d;
            send_q <= send_d;
        end
    end

    assign data_o = data_q;
    assign send_o = send_q;

endmodule : thresh_out_reg

// File: rtl/threshold_pixel.sv
// ---------------------------------------------------------------------------
// threshold_pixel
// Downstream stage of the max-pixel fold. Takes one max token, derives a
// threshold thr = (max * RATIO_NUM) >> RATIO_SHIFT, then binarises exactly
// PIXEL_COUNT pixels from In1 onto Out1 (pixel > thr -> FG, else BG) and
// returns to waiting for the next max token.
//
// Build option: THRESH_INVERT_EN (see thresh_out_reg) swaps FG/BG.
//
// Ports:
//   CLK    in      clock, all state changes on the rising edge
//   RESET  in      asynchronous, active-high reset
//   Max    slave   max token channel (DATA, SEND in; ACK out; COUNT ignored)
//   In1    slave   pixel channel     (DATA, SEND in; ACK out; COUNT ignored)
//   Out1   master  binarised pixels  (DATA, SEND, COUNT=1 out; RDY in;
//                                     ACK ignored)
// RDY on Max / In1 is an informational "would accept now" level.
// ---------------------------------------------------------------------------
module threshold_pixel
    import thresh_pkg::*;
#(
    parameter int unsigned PIXEL_COUNT = 262144,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned RATIO_NUM   = 1,
    parameter int unsigned RATIO_SHIFT = 1,
    parameter int unsigned FG_VAL      = FG_VAL_DEF,
    parameter int unsigned BG_VAL      = BG_VAL_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    threshold_pixel_if.slave  Max,
    threshold_pixel_if.slave  In1,
    threshold_pixel_if.master Out1
);

    // Threshold is kept wide enough that max * RATIO_NUM never truncates.
    localparam int unsigned       THR_W    = DATA_W + 8;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(PIXEL_COUNT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [THR_W-1:0]  thr_q, thr_d;

    logic [THR_W-1:0]  max_ext;
    logic [THR_W-1:0]  ratio_ext;
    logic [THR_W-1:0]  thr_calc;
    logic              max_take;
    logic              fire;

    assign max_ext   = THR_W'(Max.DATA);
    assign ratio_ext = THR_W'(8'(RATIO_NUM));
    assign thr_calc  = (max_ext * ratio_ext) >> RATIO_SHIFT;

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        thr_d     = thr_q;
        max_take  = 1'b0;
        fire      = 1'b0;

        case (state_q)
            WAIT_MAX: begin
                // Pixels are never taken here, even if In1 is valid too.
                max_take = Max.SEND;
                if (Max.SEND) begin
                    thr_d     = thr_calc;
                    pix_cnt_d = '0;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                // Out1_RDY is sampled at fire; downstream keeps one slot of
                // slack for the token already in the output register.
                fire = In1.SEND & Out1.RDY;
                if (fire) begin
                    if (pix_cnt_q == LAST_IDX) begin
                        pix_cnt_d = '0;
                        state_d   = WAIT_MAX;
                    end else begin
                        pix_cnt_d = pix_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = WAIT_MAX;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so
    // all registers see the same pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= WAIT_MAX;
            pix_cnt_q <= '0;
            thr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            thr_q     <= thr_d;
        end
    end

    thresh_out_reg #(
        .DATA_W (DATA_W),
        .THR_W  (THR_W),
        .FG_VAL (FG_VAL),
        .BG_VAL (BG_VAL)
    ) u_out_reg (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .fire_i (fire),
        .pix_i  (In1.DATA),
        .thr_i  (thr_q),
        .data_o (Out1.DATA),
        .send_o (Out1.SEND)
    );

    // The acks are combinational from inputs, and reset leaves the FSM in
    // WAIT_MAX, so they are masked explicitly while RESET is high.
    assign Max.ACK    = max_take & ~RESET;
    assign In1.ACK    = fire & ~RESET;
    assign Max.RDY    = (state_q == WAIT_MAX) & ~RESET;
    assign In1.RDY    = (state_q == STREAM) & Out1.RDY & ~RESET;
    assign Out1.COUNT = TOKCOUNT_W'(1);

    // Token counts and the downstream ack play no part in this block.
    logic unused_inputs;
    assign unused_inputs = ^{Max.COUNT, In1.COUNT, Out1.ACK};

endmodule : threshold_pixel

// File: tb/tb_threshold_pixel.sv
// ---------------------------------------------------------------------------
// tb_threshold_pixel
// Three threshold_pixel instances share one stimulus stream:
//   u0 : PIXEL_COUNT=4, thr = max/2, FG=255 BG=0
//   u1 : PIXEL_COUNT=1, thr = max*4 (can exceed the pixel range)
//   u2 : PIXEL_COUNT=8, thr = (max*3)>>2, FG=0xA5 BG=0x3C
// Each has a frame-level reference model (waiting flag, threshold, pixels
// left, expected next output) advanced once per cycle.
// ---------------------------------------------------------------------------
module tb_threshold_pixel;

`ifdef THRESH_INVERT_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       max_send = 1'b0;
    logic [7:0] max_data = 8'd0;
    logic       in_send = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       rdy = 1'b0;
    logic       out_ack = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model, one slot per instance.
    bit         m_wait  [3];
    int         m_thr   [3];
    int         m_left  [3];
    bit         m_esend [3];
    logic [7:0] m_edata [3];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called on every falling edge: compares the DUT against the model, then
    // advances the model to what the coming rising edge must produce.
    task automatic mon(input int g, input int cnt, input int num, input int sh,
                       input int fg, input int bg,
                       input logic mack, input logic iack, input logic osend,
                       input logic [7:0] odata, input logic [15:0] ocnt);
        bit    exp_mack;
        bit    exp_iack;
        bit    hi;
        string u;
        u = $sformatf("u%0d", g);
        if (rst) begin
            check({u, "_rst_max_ack"},   mack,  0);
            check({u, "_rst_in_ack"},    iack,  0);
            check({u, "_rst_out_send"},  osend, 0);
            check({u, "_rst_out_data"},  odata, 0);
            m_wait[g]  = 1'b1;
            m_left[g]  = 0;
            m_esend[g] = 1'b0;
            m_edata[g] = 8'd0;
            return;
        end
        check({u, "_out_send"},  osend, m_esend[g]);
        check({u, "_out_data"},  odata, m_edata[g]);
        check({u, "_out_count"}, ocnt,  1);

        exp_mack = m_wait[g] && max_send;
        exp_iack = !m_wait[g] && in_send && rdy;
        check({u, "_max_ack"}, mack, exp_mack);
        check({u, "_in_ack"},  iack, exp_iack);

        m_esend[g] = 1'b0;
        if (exp_mack) begin
            m_thr[g]  = (int'(max_data) * num) >> sh;
            m_left[g] = cnt;
            m_wait[g] = 1'b0;
        end else if (exp_iack) begin
            hi = int'(in_data) > m_thr[g];
            if (INV) hi = !hi;
            m_edata[g] = hi ? fg[7:0] : bg[7:0];
            m_esend[g] = 1'b1;
            m_left[g]--;
            if (m_left[g] == 0) m_wait[g] = 1'b1;
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CNT = (g == 0) ? 4   : (g == 1) ? 1 : 8;
        localparam int NUM = (g == 0) ? 1   : (g == 1) ? 4 : 3;
        localparam int SH  = (g == 0) ? 1   : (g == 1) ? 0 : 2;
        localparam int FG  = (g == 2) ? 165 : 255;
        localparam int BG  = (g == 2) ? 60  : 0;

        threshold_pixel_if #(.DATA_W(8)) mx ();
        threshold_pixel_if #(.DATA_W(8)) px ();
        threshold_pixel_if #(.DATA_W(8)) ox ();

        assign mx.DATA  = max_data;
        assign mx.SEND  = max_send;
        assign mx.COUNT = 16'h1;
        assign px.DATA  = in_data;
        assign px.SEND  = in_send;
        assign px.COUNT = 16'h1;
        assign ox.RDY   = rdy;
        assign ox.ACK   = out_ack;

        threshold_pixel #(
            .PIXEL_COUNT (CNT),
            .DATA_W      (8),
            .RATIO_NUM   (NUM),
            .RATIO_SHIFT (SH),
            .FG_VAL      (FG),
            .BG_VAL      (BG)
        ) u_dut (
            .CLK   (clk),
            .RESET (rst),
            .Max   (mx),
            .In1   (px),
            .Out1  (ox)
        );

        always @(negedge clk) begin
            mon(g, CNT, NUM, SH, FG, BG, mx.ACK, px.ACK, ox.SEND, ox.DATA, ox.COUNT);
        end
    end

    // Inputs change 1 time unit after the rising edge.
    task automatic step(input bit ms, input logic [7:0] md, input bit is,
                        input logic [7:0] id, input bit r);
        max_send = ms;
        max_data = md;
        in_send  = is;
        in_data  = id;
        rdy      = r;
        out_ack  = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    // Feed enough pixels that every instance finishes its frame.
    task automatic drain();
        repeat (9) step(1'b0, 8'd0, 1'b1, 8'($urandom), 1'b1);
    endtask

    initial begin
        logic [7:0] pix;
        repeat (2) @(posedge clk);
        #1;
        step(1'b1, 8'd77, 1'b1, 8'd5, 1'b1);   // Max while still in reset
        rst = 1'b0;

        // Simultaneous Max and pixel: only Max is taken. thr(u0)=100.
        step(1'b1, 8'd200, 1'b1, 8'd99, 1'b1);
        step(1'b0, 8'd0, 1'b1, 8'd99,  1'b1);
        step(1'b0, 8'd0, 1'b1, 8'd100, 1'b1);
        step(1'b0, 8'd0, 1'b1, 8'd101, 1'b1);
        step(1'b0, 8'd0, 1'b1, 8'd255, 1'b1);

        // Max held high through a frame, with a 3-cycle Out1_RDY stall.
        step(1'b1, 8'd255, 1'b1, 8'd10,  1'b1);
        step(1'b1, 8'd255, 1'b1, 8'd200, 1'b1);
        repeat (3) step(1'b1, 8'd255, 1'b1, 8'd50, 1'b0);
        step(1'b1, 8'd255, 1'b1, 8'd127, 1'b1);
        step(1'b1, 8'd255, 1'b1, 8'd128, 1'b1);
        step(1'b1, 8'd255, 1'b1, 8'd5,   1'b1);
        step(1'b1, 8'd255, 1'b1, 8'd126, 1'b1);
        step(1'b0, 8'd0,   1'b0, 8'd0,   1'b1);
        drain();

        // Max = 0: only pixel 0 is background.
        step(1'b1, 8'd0, 1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b1, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b1, 8'd1, 1'b1);
        drain();

        // Max = 100: u1 threshold 400, pixel 255 stays background.
        step(1'b1, 8'd100, 1'b0, 8'd0,   1'b1);
        step(1'b0, 8'd0,   1'b1, 8'd255, 1'b1);
        drain();

        // Max = 200, pixels 50 and 150.
        step(1'b1, 8'd200, 1'b0, 8'd0,   1'b1);
        step(1'b0, 8'd0,   1'b1, 8'd50,  1'b1);
        step(1'b0, 8'd0,   1'b1, 8'd150, 1'b1);
        drain();

        // Reset in the middle of a frame (u2 at pixel count 5).
        step(1'b1, 8'd50, 1'b0, 8'd0, 1'b1);
        repeat (5) step(1'b0, 8'd0, 1'b1, 8'($urandom), 1'b1);
        rst = 1'b1;
        repeat (2) step(1'b1, 8'd60, 1'b1, 8'd90, 1'b1);
        rst = 1'b0;
        step(1'b1, 8'd60, 1'b1, 8'd90, 1'b1);
        step(1'b0, 8'd0,  1'b1, 8'd20, 1'b1);
        drain();

        // Randomised traffic with occasional resets; pixels are biased
        // towards u0's current threshold to exercise the equality edge.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 499) == 0);
            pix = ($urandom_range(0, 3) == 0) ? 8'(m_thr[0]) : 8'($urandom);
            step($urandom_range(0, 99) < 30, 8'($urandom),
                 $urandom_range(0, 99) < 70, pix,
                 $urandom_range(0, 99) < 75);
        end
        rst = 1'b0;
        step(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_threshold_pixel
